dm_banked_ctrl: RTL and testbench

Parametrised byte-addressed data memory for the multi-cycle MIPS core. It replaces the fixed 2 KiB, word-only, zero-latency data memory.
- Adds byte, halfword and word access with sign or zero extension on loads.
- Adds a req/ready handshake with configurable wait states.
- Flags misaligned and out-of-range accesses.
- Sits between the core's MEM stage and the memory array; memory order is big-endian (byte at addr is the word MSB).

---
 rtl/dm_banked_ctrl_if.sv | 24 ++
 rtl/dm_banked_ctrl.sv | 184 ++++++++++++++++++
 tb/tb_dm_banked_ctrl.sv | 185 ++++++++++++++++++
 3 files changed

// File: rtl/dm_banked_ctrl_if.sv
// Request/response bundle between the MEM stage (master) and the banked data memory (slave).
interface dm_banked_ctrl_if;
    logic        req;
    logic        we;
    logic [1:0]  size;
    logic        sign_ext;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        ready;
    logic        err;
    logic        busy;
    logic        halt;

    modport master (
        output req, we, size, sign_ext, addr, wdata,
        input  rdata, ready, err, busy, halt
    );

    modport slave (
        input  req, we, size, sign_ext, addr, wdata,
        output rdata, ready, err, busy, halt
    );
endinterface

// File: rtl/dm_banked_ctrl.sv
// Big-endian byte/half/word data memory; ready pulses LATENCY+1 cycles after the req edge.
// req is taken only while idle (busy=0) and never queued; halt detector built only with DM_HALT_EN.
module dm_banked_ctrl #(
    parameter int         DEPTH     = 2048,
    parameter int         LATENCY   = 0,
    parameter int         HALT_ADDR = 128,
    parameter logic [7:0] HALT_VAL  = 8'hFF
) (
    input  logic            clk,
    input  logic            rst_n,
    dm_banked_ctrl_if.slave bus
);
    localparam int IW = $clog2(DEPTH);

    if (DEPTH < 4 || (DEPTH & (DEPTH - 1)) != 0 || LATENCY < 0 || LATENCY > 15 ||
        HALT_ADDR < 0 || HALT_ADDR >= DEPTH) begin : g_bad_params
        $error("dm_banked_ctrl: illegal DEPTH/LATENCY/HALT_ADDR");
    end

    typedef enum logic {IDLE, ACCESS} state_t;

    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        we_q, we_d;
    logic [1:0]  size_q, size_d;
    logic        sgn_q, sgn_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [31:0] rdata_q, rdata_d;
    logic        ready_q, ready_d;
    logic        err_q, err_d;

    logic [7:0]    mem [DEPTH];
    logic [IW-1:0] a0, a1, a2, a3;
    logic [7:0]    b0, b1, b2, b3;
    logic [31:0]   load_dat;
    logic          commit;
    logic          bad;

    assign commit = (state_q == ACCESS) && (cnt_q == 4'd0);

    // Accesses are aligned when legal, so the +1..+3 byte indices never wrap.
    assign a0 = addr_q[IW-1:0];
    assign a1 = a0 + IW'(1);
    assign a2 = a0 + IW'(2);
    assign a3 = a0 + IW'(3);
    assign b0 = mem[a0];
    assign b1 = mem[a1];
    assign b2 = mem[a2];
    assign b3 = mem[a3];

    always_comb begin
        bad = (addr_q >= 32'(DEPTH));
        case (size_q)
            2'b00:   bad = bad;
            2'b01:   bad = bad | addr_q[0];
            2'b10:   bad = bad | (addr_q[1:0] != 2'b00);
            default: bad = 1'b1;
        endcase
    end

    always_comb begin
        load_dat = '0;
        case (size_q)
            2'b00:   load_dat = {{24{sgn_q & b0[7]}}, b0};
            2'b01:   load_dat = {{16{sgn_q & b0[7]}}, b0, b1};
            default: load_dat = {b0, b1, b2, b3};
        endcase
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        we_d    = we_q;
        size_d  = size_q;
        sgn_d   = sgn_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        ready_d = 1'b0;
        err_d   = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.req) begin
                    we_d    = bus.we;
                    size_d  = bus.size;
                    sgn_d   = bus.sign_ext;
                    addr_d  = bus.addr;
                    wdata_d = bus.wdata;
                    cnt_d   = 4'(LATENCY);
                    state_d = ACCESS;
                end
            end
            ACCESS: begin
                if (cnt_q != 4'd0) begin
                    cnt_d = cnt_q - 4'd1;
                end else begin
                    ready_d = 1'b1;
                    err_d   = bad;
                    rdata_d = (bad || we_q) ? 32'h0 : load_dat;
                    state_d = IDLE;
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            we_q    <= 1'b0;
            size_q  <= '0;
            sgn_q   <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            ready_q <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            we_q    <= we_d;
            size_q  <= size_d;
            sgn_q   <= sgn_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            ready_q <= ready_d;
            err_q   <= err_d;
        end
    end

    // Array is deliberately outside the reset domain: contents survive rst_n.
    always_ff @(posedge clk) begin
        if (commit && we_q && !bad) begin
            case (size_q)
                2'b00: mem[a0] <= wdata_q[7:0];
                2'b01: begin
                    mem[a0] <= wdata_q[15:8];
                    mem[a1] <= wdata_q[7:0];
                end
                default: begin
                    mem[a0] <= wdata_q[31:24];
                    mem[a1] <= wdata_q[23:16];
                    mem[a2] <= wdata_q[15:8];
                    mem[a3] <= wdata_q[7:0];
                end
            endcase
        end
    end

    assign bus.rdata = rdata_q;
    assign bus.ready = ready_q;
    assign bus.err   = err_q;
    assign bus.busy  = (state_q == ACCESS);

`ifdef DM_HALT_EN
    localparam logic [IW-1:0] HALT_IDX = IW'(HALT_ADDR);

    logic st_done_q, st_done_d;
    logic halt_q, halt_d;

    // The sentinel is inspected the cycle after the store lands in the array.
    always_comb begin
        st_done_d = commit && we_q && !bad;
        halt_d    = halt_q | (st_done_q && (mem[HALT_IDX] == HALT_VAL));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            st_done_q <= 1'b0;
            halt_q    <= 1'b0;
        end else begin
            st_done_q <= st_done_d;
            halt_q    <= halt_d;
        end
    end

    assign bus.halt = halt_q;
`else
    assign bus.halt = 1'b0;
`endif

endmodule

// File: tb/tb_dm_banked_ctrl.sv
// Directed bench for dm_banked_ctrl: a LATENCY=0 and a LATENCY=3 instance share clk/rst_n.
module tb_dm_banked_ctrl;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    dm_banked_ctrl_if if0();
    dm_banked_ctrl_if if3();

    dm_banked_ctrl #(.LATENCY(0)) u_dm0 (.clk(clk), .rst_n(rst_n), .bus(if0));
    dm_banked_ctrl #(.LATENCY(3)) u_dm3 (.clk(clk), .rst_n(rst_n), .bus(if3));

    int total = 0;
    int bad = 0;

    logic [31:0] rd;
    logic        e;
    int          lat;

`ifdef DM_HALT_EN
    localparam logic HALT_EXP = 1'b1;
    always @(posedge if0.halt) begin
        for (int i = 0; i < 32; i++)
            $display("dump %0d: %h", i * 4,
                     {u_dm0.mem[4*i], u_dm0.mem[4*i+1], u_dm0.mem[4*i+2], u_dm0.mem[4*i+3]});
    end
`else
    localparam logic HALT_EXP = 1'b0;
`endif

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", tag, got, exp);
        end
    endtask

    task automatic drive(input bit inst, input bit rq, input bit w, input logic [1:0] sz,
                         input bit sg, input logic [31:0] a, input logic [31:0] wd);
        if (inst) begin
            if3.req = rq; if3.we = w; if3.size = sz; if3.sign_ext = sg; if3.addr = a; if3.wdata = wd;
        end else begin
            if0.req = rq; if0.we = w; if0.size = sz; if0.sign_ext = sg; if0.addr = a; if0.wdata = wd;
        end
    endtask

    // Issues one request from a negedge and returns at the negedge of the ready cycle.
    task automatic access(input bit inst, input bit w, input logic [1:0] sz, input bit sg,
                          input logic [31:0] a, input logic [31:0] wd,
                          output logic [31:0] r, output logic er, output int l);
        bit done;
        done = 1'b0;
        r = '0; er = 1'b0; l = 0;
        drive(inst, 1'b1, w, sz, sg, a, wd);
        @(posedge clk);
        #1 drive(inst, 1'b0, 1'b0, 2'b00, 1'b0, 32'h0, 32'h0);
        for (int k = 0; k < 40 && !done; k++) begin
            @(posedge clk);
            l++;
            @(negedge clk);
            if (inst ? if3.ready : if0.ready) begin
                done = 1'b1;
                r  = inst ? if3.rdata : if0.rdata;
                er = inst ? if3.err : if0.err;
            end
        end
        if (!done) check_val("ready_timeout", 32'd0, 32'd1);
    endtask

    initial begin
        drive(1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 32'h0, 32'h0);
        drive(1'b1, 1'b0, 1'b0, 2'b00, 1'b0, 32'h0, 32'h0);
        repeat (3) @(negedge clk);
        check_val("rst_rdata", if0.rdata, 32'h0);
        check_val("rst_ready", {if0.ready, if3.ready}, 32'h0);
        check_val("rst_err", {if0.err, if3.err}, 32'h0);
        check_val("rst_busy", {if0.busy, if3.busy}, 32'h0);
        check_val("rst_halt", {if0.halt, if3.halt}, 32'h0);
        rst_n = 1'b1;
        @(negedge clk);

        // word store/load, LATENCY=0
        access(1'b0, 1'b1, 2'b10, 1'b0, 32'd8, 32'h11223344, rd, e, lat);
        check_val("t1_st_lat", lat, 32'd1);
        check_val("t1_st_err", e, 32'd0);
        check_val("t1_st_rdata", rd, 32'h0);
        check_val("t1_mem8", u_dm0.mem[8], 32'h11);
        access(1'b0, 1'b0, 2'b10, 1'b0, 32'd8, 32'h0, rd, e, lat);
        check_val("t1_ld_lat", lat, 32'd1);
        check_val("t1_ld_word", rd, 32'h11223344);
        check_val("t1_ld_err", e, 32'd0);

        // sub-word accesses and extension
        access(1'b0, 1'b0, 2'b00, 1'b1, 32'd9, 32'h0, rd, e, lat);
        check_val("t2_lb9", rd, 32'h00000022);
        access(1'b0, 1'b1, 2'b00, 1'b0, 32'd9, 32'h00000080, rd, e, lat);
        access(1'b0, 1'b0, 2'b00, 1'b1, 32'd9, 32'h0, rd, e, lat);
        check_val("t2_lb9_sext", rd, 32'hFFFFFF80);
        access(1'b0, 1'b0, 2'b00, 1'b0, 32'd9, 32'h0, rd, e, lat);
        check_val("t2_lb9_zext", rd, 32'h00000080);
        access(1'b0, 1'b1, 2'b01, 1'b0, 32'd10, 32'h0000BEEF, rd, e, lat);
        access(1'b0, 1'b0, 2'b01, 1'b1, 32'd10, 32'h0, rd, e, lat);
        check_val("t2_lh10_sext", rd, 32'hFFFFBEEF);
        access(1'b0, 1'b0, 2'b01, 1'b0, 32'd10, 32'h0, rd, e, lat);
        check_val("t2_lh10_zext", rd, 32'h0000BEEF);
        access(1'b0, 1'b0, 2'b10, 1'b1, 32'd8, 32'h0, rd, e, lat);
        check_val("t2_lw8_mix", rd, 32'h1180BEEF);

        // error cases
        access(1'b0, 1'b1, 2'b10, 1'b0, 32'd4, 32'hCAFEF00D, rd, e, lat);
        access(1'b0, 1'b1, 2'b10, 1'b0, 32'd6, 32'h12345678, rd, e, lat);
        check_val("t3_sw6_err", e, 32'd1);
        access(1'b0, 1'b0, 2'b10, 1'b0, 32'd4, 32'h0, rd, e, lat);
        check_val("t3_mem4_kept", rd, 32'hCAFEF00D);
        check_val("t3_lw4_err", e, 32'd0);
        access(1'b0, 1'b0, 2'b10, 1'b0, 32'd2048, 32'h0, rd, e, lat);
        check_val("t3_oor_err", e, 32'd1);
        check_val("t3_oor_rdata", rd, 32'h0);
        access(1'b0, 1'b0, 2'b10, 1'b0, 32'h0001_0008, 32'h0, rd, e, lat);
        check_val("t3_hiaddr_err", e, 32'd1);
        access(1'b0, 1'b0, 2'b11, 1'b0, 32'd8, 32'h0, rd, e, lat);
        check_val("t3_size11_err", e, 32'd1);
        access(1'b0, 1'b1, 2'b01, 1'b0, 32'd13, 32'h0000AAAA, rd, e, lat);
        check_val("t3_sh_odd_err", e, 32'd1);
        access(1'b0, 1'b1, 2'b10, 1'b0, 32'd2044, 32'hA1B2C3D4, rd, e, lat);
        check_val("t3_sw_top_err", e, 32'd0);
        access(1'b0, 1'b0, 2'b00, 1'b0, 32'd2047, 32'h0, rd, e, lat);
        check_val("t3_lb_last", rd, 32'h000000D4);
        check_val("t3_lb_last_err", e, 32'd0);

        // LATENCY=3 pulse timing; a load req held through busy must not disturb the store
        drive(1'b1, 1'b1, 1'b1, 2'b10, 1'b0, 32'd16, 32'h55667788);
        for (int k = 0; k <= 4; k++) begin
            @(posedge clk);
            if (k == 0) #1 drive(1'b1, 1'b1, 1'b0, 2'b10, 1'b0, 32'd16, 32'h0);
            @(negedge clk);
            check_val($sformatf("t4_busy_e%0d", k), if3.busy, 32'(k < 4));
            check_val($sformatf("t4_ready_e%0d", k), if3.ready, 32'(k == 4));
        end
        check_val("t4_st_err", if3.err, 32'd0);
        check_val("t4_mem16", u_dm3.mem[16], 32'h55);
        for (int k = 0; k <= 4; k++) begin
            @(posedge clk);
            if (k == 0) #1 drive(1'b1, 1'b0, 1'b0, 2'b00, 1'b0, 32'h0, 32'h0);
            @(negedge clk);
            check_val($sformatf("t4b_busy_e%0d", k), if3.busy, 32'(k < 4));
            check_val($sformatf("t4b_ready_e%0d", k), if3.ready, 32'(k == 4));
        end
        check_val("t4b_rdata", if3.rdata, 32'h55667788);

        // reset in the middle of a pending store
        drive(1'b1, 1'b1, 1'b1, 2'b10, 1'b0, 32'd16, 32'hDEADBEEF);
        @(posedge clk);
        #1 drive(1'b1, 1'b0, 1'b0, 2'b00, 1'b0, 32'h0, 32'h0);
        repeat (2) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check_val("t5_busy", if3.busy, 32'd0);
        check_val("t5_ready", if3.ready, 32'd0);
        check_val("t5_err", if3.err, 32'd0);
        check_val("t5_rdata", if3.rdata, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        access(1'b1, 1'b0, 2'b10, 1'b0, 32'd16, 32'h0, rd, e, lat);
        check_val("t5_ld_lat", lat, 32'd4);
        check_val("t5_ld_kept", rd, 32'h55667788);

        // halt detector
        access(1'b0, 1'b1, 2'b00, 1'b0, 32'd128, 32'h000000FE, rd, e, lat);
        repeat (2) @(negedge clk);
        check_val("t6_halt_fe", if0.halt, 32'd0);
        access(1'b0, 1'b1, 2'b00, 1'b0, 32'd128, 32'h000000FF, rd, e, lat);
        check_val("t6_halt_commit", if0.halt, 32'd0);
        @(negedge clk);
        check_val("t6_halt_next", if0.halt, 32'(HALT_EXP));
        access(1'b0, 1'b1, 2'b00, 1'b0, 32'd128, 32'h00000000, rd, e, lat);
        repeat (3) @(negedge clk);
        check_val("t6_halt_sticky", if0.halt, 32'(HALT_EXP));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
